// File: rtl/z80_bus_decoder_if.sv
// rtl/z80_bus_decoder_if.sv - Z80 CPU-side bus bundle between the core and the region decoder
interface z80_bus_decoder_if #(
    parameter int NUM_REGIONS = 4
);
    logic [15:0]            addr;
    logic [7:0]             data_in;
    logic                   rd_n;
    logic                   wr_n;
    logic                   mreq_n;
    logic                   iorq_n;
    logic                   m1_n;
    logic                   memrd;
    logic                   memwr;
    logic                   iord;
    logic                   iowr;
    logic                   inta;
    logic [NUM_REGIONS-1:0] region_ena;
    logic                   wait_n;
    logic                   cfg_sel;
    logic [7:0]             cfg_rd_data;

    modport master (
        output addr, data_in, rd_n, wr_n, mreq_n, iorq_n, m1_n,
        input  memrd, memwr, iord, iowr, inta, region_ena, wait_n, cfg_sel, cfg_rd_data
    );

    modport slave (
        input  addr, data_in, rd_n, wr_n, mreq_n, iorq_n, m1_n,
        output memrd, memwr, iord, iowr, inta, region_ena, wait_n, cfg_sel, cfg_rd_data
    );
endinterface

// File: rtl/z80_bus_decoder.sv
// rtl/z80_bus_decoder.sv - Z80 strobe decode, programmable region match and per-region wait states
module z80_bus_decoder #(
    parameter int         NUM_REGIONS = 4,
    parameter logic [7:0] CFG_IO_BASE = 8'h40,
    parameter int         WAIT_W      = 3
) (
    input logic              clk,
    input logic              rst_n,
    z80_bus_decoder_if.slave bus
);
    localparam int         IDX_W    = $clog2(NUM_REGIONS);
    localparam logic [8:0] WIN_SIZE = 9'(4 * NUM_REGIONS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    logic [7:0]        base_q [NUM_REGIONS];
    logic [7:0]        base_d [NUM_REGIONS];
    logic [7:0]        mask_q [NUM_REGIONS];
    logic [7:0]        mask_d [NUM_REGIONS];
    logic [7:0]        ctrl_q [NUM_REGIONS];
    logic [7:0]        ctrl_d [NUM_REGIONS];
    logic              iowr_q;
    logic              iowr_d;
    logic              mreq_n_q;
    logic              mreq_n_d;
    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] cnt_q;
    logic [WAIT_W-1:0] cnt_d;
    logic              wait_n_q;
    logic              wait_n_d;

    logic [8:0]             cfg_off;
    logic                   win_hit;
    logic                   cfg_ok;
    logic [IDX_W-1:0]       cfg_idx;
    logic [1:0]             cfg_reg;
    logic                   cfg_we;
    logic [NUM_REGIONS-1:0] region_ena_c;
    logic                   region_hit;
    logic [WAIT_W-1:0]      hit_wait;
    logic [7:0]             rd_data_c;

    assign bus.memrd = ~bus.rd_n & ~bus.mreq_n;
    assign bus.memwr = ~bus.wr_n & ~bus.mreq_n;
    assign bus.iord  = ~bus.rd_n & ~bus.iorq_n;
    assign bus.iowr  = ~bus.wr_n & ~bus.iorq_n;
    assign bus.inta  = ~bus.m1_n & ~bus.iorq_n;

    // Addresses below the window wrap to >= 256 in 9 bits, so one compare covers both bounds.
    assign cfg_off = {1'b0, bus.addr[7:0]} - {1'b0, CFG_IO_BASE};
    assign win_hit = (cfg_off < WIN_SIZE);
    assign cfg_ok  = win_hit & ~bus.inta;
    assign cfg_idx = IDX_W'(cfg_off >> 2);
    assign cfg_reg = cfg_off[1:0];
    assign cfg_we  = bus.iowr & ~iowr_q & cfg_ok;

    assign bus.cfg_sel     = bus.iord & cfg_ok;
    assign bus.cfg_rd_data = rd_data_c;
    assign bus.region_ena  = region_ena_c;
    assign bus.wait_n      = wait_n_q;

    always_comb begin
        rd_data_c = 8'h00;
        if (win_hit) begin
            case (cfg_reg)
                2'd0:    rd_data_c = base_q[cfg_idx];
                2'd1:    rd_data_c = mask_q[cfg_idx];
                2'd2:    rd_data_c = ctrl_q[cfg_idx];
                default: rd_data_c = 8'h00;
            endcase
        end
    end

    always_comb begin
        region_ena_c = '0;
        region_hit   = 1'b0;
        hit_wait     = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!region_hit && ctrl_q[i][7] &&
                ((bus.addr[15:8] & mask_q[i]) == (base_q[i] & mask_q[i]))) begin
                region_hit      = 1'b1;
                region_ena_c[i] = 1'b1;
                hit_wait        = ctrl_q[i][WAIT_W-1:0];
            end
        end
    end

    always_comb begin
        base_d = base_q;
        mask_d = mask_q;
        ctrl_d = ctrl_q;
        if (cfg_we) begin
            case (cfg_reg)
                2'd0:    base_d[cfg_idx] = bus.data_in;
                2'd1:    mask_d[cfg_idx] = bus.data_in;
                2'd2:    ctrl_d[cfg_idx] = bus.data_in;
                default: ;
            endcase
        end
        iowr_d   = bus.iowr;
        mreq_n_d = bus.mreq_n;
    end

    // The wait count is latched on entry so later table writes cannot stretch a running wait.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wait_n_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (!bus.mreq_n && mreq_n_q) begin
                    if (region_hit && (hit_wait != '0)) begin
                        state_d  = ST_WAIT;
                        cnt_d    = hit_wait;
                        wait_n_d = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.mreq_n) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == WAIT_W'(1)) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    wait_n_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (bus.mreq_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                base_q[i] <= (i == 1) ? 8'h80 : 8'h00;
                mask_q[i] <= (i == 0) ? 8'h80 : ((i == 1) ? 8'hFF : 8'h00);
                ctrl_q[i] <= (i < 2) ? 8'h80 : 8'h00;
            end
            iowr_q   <= 1'b0;
            mreq_n_q <= 1'b1;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wait_n_q <= 1'b1;
        end else begin
            base_q   <= base_d;
            mask_q   <= mask_d;
            ctrl_q   <= ctrl_d;
            iowr_q   <= iowr_d;
            mreq_n_q <= mreq_n_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wait_n_q <= wait_n_d;
        end
    end
endmodule

// File: doc/z80_bus_decoder.md
# z80_bus_decoder

Programmable successor to the fixed Z80 address decoder. Decodes the Z80 control strobes and matches the address against NUM_REGIONS run-time programmable memory regions, producing a one-hot region enable. Generates per-region memory wait states on wait_n. The region table is programmed by the CPU through an I/O register window. Sits between the Z80 core and the memory/peripheral select logic.

## Interface
- NUM_REGIONS, 4, number of decoded memory regions (2..16)
- CFG_IO_BASE, 8'h40, I/O port of region 0 BASE register; region i occupies ports CFG_IO_BASE+4*i .. +3
- WAIT_W, 3, width of the wait-state count field (max WAIT_W=4)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- addr  in  16  Z80 address bus
- data_in  in  8  Z80 data bus (CPU write data)
- rd_n, wr_n, mreq_n, iorq_n, m1_n  in  1 each  Z80 control strobes, active-low
- memrd, memwr, iord, iowr, inta  out  1 each  decoded strobes, combinational, same equations as the previous decoder (~rd_n&~mreq_n, etc.)
- region_ena  out  NUM_REGIONS  one-hot (or zero) region match, combinational
- wait_n  out  1  registered Z80 WAIT, active-low
- cfg_sel  out  1  high when iord targets the config window; enables cfg_rd_data onto the bus
- cfg_rd_data  out  8  config register readback, combinational

## Operation
- Per region i there are three 8-bit registers: BASE (offset 0), MASK (offset 1), CTRL (offset 2). CTRL[7] is the enable bit; CTRL[WAIT_W-1:0] is the wait-state count. Offset 3 is reserved: writes are ignored and reads return 8'h00.
- Reset values:
  - Region 0: BASE=00, MASK=80, CTRL=80 (0x0000–0x7FFF, 0 waits).
  - Region 1: BASE=80, MASK=FF, CTRL=80 (0x8000–0x80FF).
  - All other regions: 00/00/00 (disabled).
- Match i = CTRL_i[7] & ((addr[15:8] & MASK_i) == (BASE_i & MASK_i)). This is independent of the strobes.
- Priority: the lowest matching index wins. region_ena has at most one bit set, and is all-zero if no region matches.
- The config window is hit when addr[7:0] is in the range CFG_IO_BASE .. CFG_IO_BASE+4*NUM_REGIONS-1. addr[15:8] is ignored.
- Config write:
  - Occurs on the first clock edge at which iowr is sampled high while the previous sample was low (rising-edge detect on registered iowr).
  - The write goes to the addressed register from data_in. There is exactly one write per I/O cycle, however long iowr is held.
- cfg_sel = iord & window hit. cfg_rd_data returns the addressed register (00 outside the window or at offset 3).
- inta cycles (m1_n & iorq_n both low) never write and never assert cfg_sel.
- Wait FSM states:
  - IDLE → WAIT: on the edge where mreq_n is first sampled low (previous sample high) and the matched region's count W>0. The counter is loaded with W; wait_n is registered low.
  - IDLE → HOLD: on the same edge when W=0 or no region matches.
  - WAIT: the counter decrements each cycle. When it reaches 1, the next edge goes to HOLD with wait_n=1.
  - HOLD → IDLE: when mreq_n is sampled high.
  - WAIT → IDLE immediately (wait_n=1) if mreq_n is sampled high (aborted cycle).
- W and the region are captured at the IDLE→WAIT edge. Config writes or address changes after that edge do not alter the running wait.
- Refresh cycles (mreq_n low with rd_n and wr_n high) are treated like any memory cycle.

## Timing
- All decoded strobes, region_ena, cfg_sel and cfg_rd_data are combinational with zero latency.
- wait_n is low for exactly W consecutive cycles. It starts at the edge where mreq_n is first sampled low and rises on the W-th following edge.
- A config write takes effect at the detecting edge and is visible to decode in the next cycle.
- Reset state: FSM=IDLE, wait_n=1, register table at reset values, edge-detect flops as if strobes were inactive. Combinational outputs follow the inputs and reset table.
- Reset asserted mid-wait: wait_n=1 immediately (asynchronously).

## Test plan
- Reset defaults: after rst_n release, addr=0x1234 → region_ena=0001; addr=0x8000 → 0010; addr=0x9000 → 0000; wait_n=1.
- Config write/readback: I/O write 0x44←0x90, 0x45←0xF0, 0x46←0x83 → I/O read 0x46 gives cfg_sel=1, cfg_rd_data=0x83; addr=0x9ABC → region_ena=0010.
- Priority overlap: program region 2 as BASE=00, MASK=00, CTRL=80 → addr=0x1000 selects region 0, addr=0xC000 selects region 2.
- Wait states: region 0 CTRL=0x83, memory read at 0x0100 → wait_n low for exactly 3 cycles, then high until mreq_n rises; with CTRL=0x80 → wait_n never falls.
- Abort and reset: W=5, release mreq_n after 2 wait cycles → wait_n=1 on the next edge and the FSM is IDLE. Repeat with rst_n pulsed during the wait → wait_n=1 asynchronously and the table is restored.
- Single write and inta: hold iowr 4 cycles to 0x46 with data changing → only the first-edge value is stored; an inta cycle with addr[7:0]=0x46 → no write, cfg_sel=0.
